// File: rtl/lfsr_rand_gen.sv
// ---------------------------------------------------------------------------
// lfsr_rand_gen
//
// Multi-channel pseudo-random number generator. Each channel owns a 16-bit
// Galois LFSR (x^16 + x^14 + x^13 + x^11 + 1). A channel exposes the low WIDTH
// bits of its register each time it steps. It runs a small IDLE/RUN/HOLD
// state machine that is independent of the other channels.
//
// Parameters
//   WIDTH     output bits per channel (1..16)
//   CHANNELS  number of independent generator channels (1..8)
//   BURST     0 = free-running, N > 0 = channel stops itself after N outputs
//
// Ports
//   i_clk         sole clock, all state changes on the rising edge
//   i_rst_n       synchronous active-low reset
//   i_start       per-channel start/resume request (level sampled)
//   i_stop        per-channel pause request
//   i_seed_load   per-channel seed load strobe
//   i_seed        seed shared by all channels (0 selects the channel default)
//   o_random_out  channel c output at bits [c*WIDTH +: WIDTH]
//   o_valid       channel c produced a fresh value this cycle
//   o_busy        channel c is in RUN
//   o_done        one-cycle pulse when channel c finishes a burst
// ---------------------------------------------------------------------------
module lfsr_rand_gen #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int BURST    = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [CHANNELS-1:0]       i_start,
    input  logic [CHANNELS-1:0]       i_stop,
    input  logic [CHANNELS-1:0]       i_seed_load,
    input  logic [15:0]               i_seed,
    output logic [CHANNELS*WIDTH-1:0] o_random_out,
    output logic [CHANNELS-1:0]       o_valid,
    output logic [CHANNELS-1:0]       o_busy,
    output logic [CHANNELS-1:0]       o_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [15:0] BURST_LEN = 16'(BURST);
    localparam bit          BURST_ON  = (BURST > 0);

    // One Galois step: shift right, fold the taps back in when a 1 falls out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan

        // Channels get distinct default seeds so that they do not march in
        // lock-step after reset.
        localparam logic [15:0] DEFAULT_SEED = 16'hACE1 ^ 16'(c);

        state_t           state, state_next;
        logic [15:0]      lfsr, lfsr_next;
        logic [15:0]      count, count_next;
        logic [15:0]      count_base;
        logic [WIDTH-1:0] rand_q, rand_next;
        logic             valid_q, valid_next;
        logic             done_q, done_next;
        logic [15:0]      stepped;
        logic             burst_complete;
        logic             produce;

        assign stepped = lfsr_step(lfsr);

        // A HOLD reached by finishing a burst leaves count == BURST; a HOLD
        // reached via i_stop always has count < BURST. That distinction is
        // what decides whether a restart continues or begins a new burst.
        assign burst_complete = BURST_ON && (count == BURST_LEN);

        // Next-state logic. Priority is seed load, then stop, then start, then
        // burst completion. While o_done is pulsing the channel refuses to
        // restart, so the cycle after a finished burst always shows
        // o_valid = 0 and o_done = 0 even with i_start held.
        always_comb begin
            state_next = state;
            lfsr_next  = lfsr;
            count_next = count;
            count_base = count;
            rand_next  = rand_q;
            valid_next = 1'b0;
            done_next  = 1'b0;
            produce    = 1'b0;

            if (i_seed_load[c]) begin
                lfsr_next  = (i_seed == 16'd0) ? DEFAULT_SEED : i_seed;
                state_next = ST_IDLE;
                count_next = 16'd0;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (i_stop[c]) begin
                            state_next = ST_HOLD;
                        end else begin
                            produce = 1'b1;
                        end
                    end
                    ST_IDLE, ST_HOLD: begin
                        if (i_start[c] && !i_stop[c] && !done_q) begin
                            produce = 1'b1;
                            if (state == ST_IDLE || burst_complete) begin
                                count_base = 16'd0;
                            end
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                    end
                endcase
            end

            if (produce) begin
                lfsr_next  = stepped;
                rand_next  = stepped[WIDTH-1:0];
                valid_next = 1'b1;
                state_next = ST_RUN;
                if (BURST_ON) begin
                    count_next = count_base + 16'd1;
                    if (count_next == BURST_LEN) begin
                        done_next  = 1'b1;
                        state_next = ST_HOLD;
                    end
                end
            end
        end

        // State and output registers. Reset wins over every other input.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                state   <= ST_IDLE;
                lfsr    <= DEFAULT_SEED;
                count   <= 16'd0;
                rand_q  <= '0;
                valid_q <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state   <= state_next;
                lfsr    <= lfsr_next;
                count   <= count_next;
                rand_q  <= rand_next;
                valid_q <= valid_next;
                done_q  <= done_next;
            end
        end

        assign o_random_out[c*WIDTH +: WIDTH] = rand_q;
        assign o_valid[c]                     = valid_q;
        assign o_done[c]                      = done_q;
        assign o_busy[c]                      = (state == ST_RUN);

    end

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// ---------------------------------------------------------------------------
// tb_lfsr_rand_gen
//
// Drives a free-running instance (BURST = 0) and a burst instance (BURST = 3)
// with the same stimulus. An independent cycle model predicts every output of
// both instances. The predictions are queued when the stimulus is applied.
// They are popped and compared once the edge has happened. Hand-computed
// sequence values are checked on top of the model.
// ---------------------------------------------------------------------------
module tb_lfsr_rand_gen;

    localparam int W          = 4;
    localparam int CH         = 2;
    localparam int BURST_FREE = 0;
    localparam int BURST_LEN  = 3;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HOLD = 2;

    typedef struct packed {
        logic [CH*W-1:0] rnd;
        logic [CH-1:0]   valid;
        logic [CH-1:0]   busy;
        logic [CH-1:0]   done;
    } obs_t;

    typedef struct packed {
        obs_t f;
        obs_t b;
    } pair_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH-1:0]   start, stop, seed_load;
    logic [15:0]     seed;

    logic [CH*W-1:0] rnd_f, rnd_b;
    logic [CH-1:0]   valid_f, busy_f, done_f;
    logic [CH-1:0]   valid_b, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    pair_t exp_q[$];

    int          m_st    [2][CH];
    logic [15:0] m_lfsr  [2][CH];
    int          m_cnt   [2][CH];
    logic [W-1:0] m_out  [2][CH];
    logic        m_valid [2][CH];
    logic        m_done  [2][CH];

    always #5 clk = ~clk;

    lfsr_rand_gen #(.WIDTH(W), .CHANNELS(CH), .BURST(BURST_FREE)) dut_free (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_stop       (stop),
        .i_seed_load  (seed_load),
        .i_seed       (seed),
        .o_random_out (rnd_f),
        .o_valid      (valid_f),
        .o_busy       (busy_f),
        .o_done       (done_f)
    );

    lfsr_rand_gen #(.WIDTH(W), .CHANNELS(CH), .BURST(BURST_LEN)) dut_burst (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_stop       (stop),
        .i_seed_load  (seed_load),
        .i_seed       (seed),
        .o_random_out (rnd_b),
        .o_valid      (valid_b),
        .o_busy       (busy_b),
        .o_done       (done_b)
    );

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] galois(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic int burstOf(input int d);
        return (d == 0) ? BURST_FREE : BURST_LEN;
    endfunction

    // Reference behaviour for one rising edge of instance d.
    function automatic void modelEdge(input int d);
        for (int c = 0; c < CH; c++) begin
            logic [15:0] dflt;
            dflt = 16'hACE1 ^ 16'(c);
            if (!rst_n) begin
                m_st[d][c]    = S_IDLE;
                m_lfsr[d][c]  = dflt;
                m_cnt[d][c]   = 0;
                m_out[d][c]   = '0;
                m_valid[d][c] = 1'b0;
                m_done[d][c]  = 1'b0;
            end else if (seed_load[c]) begin
                m_lfsr[d][c]  = (seed == 16'd0) ? dflt : seed;
                m_st[d][c]    = S_IDLE;
                m_cnt[d][c]   = 0;
                m_valid[d][c] = 1'b0;
                m_done[d][c]  = 1'b0;
            end else if (m_st[d][c] == S_RUN && stop[c]) begin
                m_st[d][c]    = S_HOLD;
                m_valid[d][c] = 1'b0;
                m_done[d][c]  = 1'b0;
            end else if (m_st[d][c] == S_RUN ||
                         (start[c] && !stop[c] && !m_done[d][c])) begin
                if (m_st[d][c] != S_RUN &&
                    (m_st[d][c] == S_IDLE || m_cnt[d][c] == burstOf(d)))
                    m_cnt[d][c] = 0;
                m_lfsr[d][c]  = galois(m_lfsr[d][c]);
                m_out[d][c]   = m_lfsr[d][c][W-1:0];
                m_valid[d][c] = 1'b1;
                m_done[d][c]  = 1'b0;
                m_st[d][c]    = S_RUN;
                if (burstOf(d) > 0) begin
                    m_cnt[d][c]++;
                    if (m_cnt[d][c] == burstOf(d)) begin
                        m_done[d][c] = 1'b1;
                        m_st[d][c]   = S_HOLD;
                    end
                end
            end else begin
                m_valid[d][c] = 1'b0;
                m_done[d][c]  = 1'b0;
            end
        end
    endfunction

    function automatic obs_t modelObs(input int d);
        obs_t e;
        e = '0;
        for (int c = 0; c < CH; c++) begin
            e.rnd[c*W +: W] = m_out[d][c];
            e.valid[c]      = m_valid[d][c];
            e.busy[c]       = (m_st[d][c] == S_RUN);
            e.done[c]       = m_done[d][c];
        end
        return e;
    endfunction

    // Drive one cycle of stimulus, queue the predicted outputs, then compare
    // them against both instances just after the edge.
    task automatic applyStimulus(input logic rst, input logic [CH-1:0] st_in,
                                 input logic [CH-1:0] sp_in, input logic [CH-1:0] ld_in,
                                 input logic [15:0] sd_in);
        pair_t e;
        @(negedge clk);
        rst_n     = rst;
        start     = st_in;
        stop      = sp_in;
        seed_load = ld_in;
        seed      = sd_in;
        modelEdge(0);
        modelEdge(1);
        e.f = modelObs(0);
        e.b = modelObs(1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checkOutput("free_rnd",    32'(rnd_f),   32'(e.f.rnd));
        checkOutput("free_valid",  32'(valid_f), 32'(e.f.valid));
        checkOutput("free_busy",   32'(busy_f),  32'(e.f.busy));
        checkOutput("free_done",   32'(done_f),  32'(e.f.done));
        checkOutput("burst_rnd",   32'(rnd_b),   32'(e.b.rnd));
        checkOutput("burst_valid", 32'(valid_b), 32'(e.b.valid));
        checkOutput("burst_busy",  32'(busy_b),  32'(e.b.busy));
        checkOutput("burst_done",  32'(done_b),  32'(e.b.done));
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = '0;
        stop      = '0;
        seed_load = '0;
        seed      = '0;

        // Reset overrides a start request.
        applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 16'h0);
        applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 16'h0);
        checkOutput("rst_rnd",   32'(rnd_f),   32'h0);
        checkOutput("rst_valid", 32'(valid_f), 32'h0);
        checkOutput("rst_busy",  32'(busy_f),  32'h0);
        checkOutput("rst_done",  32'(done_b),  32'h0);

        // Channel 0 sequence from the default seed, burst of three.
        applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 16'h0);
        checkOutput("seq0_v0",   32'(rnd_f[3:0]), 32'h0);
        checkOutput("seq0_val",  32'(valid_f),    32'h1);
        checkOutput("ch1_idle",  32'(rnd_f[7:4]), 32'h0);
        applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 16'h0);
        checkOutput("seq0_v1",   32'(rnd_f[3:0]), 32'h8);
        applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 16'h0);
        checkOutput("seq0_v2",   32'(rnd_f[3:0]), 32'hC);
        checkOutput("bst_done",  32'(done_b),     32'h1);
        checkOutput("bst_v2",    32'(rnd_b[3:0]), 32'hC);
        checkOutput("bst_busy",  32'(busy_b),     32'h0);
        applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 16'h0);
        checkOutput("seq0_v3",   32'(rnd_f[3:0]), 32'hE);
        checkOutput("bst_gapv",  32'(valid_b),    32'h0);
        checkOutput("bst_gapd",  32'(done_b),     32'h0);
        applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 16'h0);
        checkOutput("seq0_v4",   32'(rnd_f[3:0]), 32'h7);
        checkOutput("bst_rest",  32'(rnd_b[3:0]), 32'hE);
        checkOutput("bst_restv", 32'(valid_b),    32'h1);

        // Stop and start together pause a running channel; releasing stop resumes it.
        applyStimulus(1'b1, 2'b01, 2'b01, 2'b00, 16'h0);
        checkOutput("hold_val",  32'(valid_f),    32'h0);
        checkOutput("hold_rnd",  32'(rnd_f[3:0]), 32'h7);
        checkOutput("hold_busy", 32'(busy_f),     32'h0);
        applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 16'h0);
        checkOutput("resume",    32'(rnd_f[3:0]), 32'h3);
        checkOutput("resume_v",  32'(valid_f),    32'h1);

        // Loading a zero seed falls back to the default seed.
        applyStimulus(1'b1, 2'b00, 2'b00, 2'b01, 16'h0);
        checkOutput("load_val",  32'(valid_f),    32'h0);
        checkOutput("load_rnd",  32'(rnd_f[3:0]), 32'h3);
        applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 16'h0);
        checkOutput("load_seq",  32'(rnd_f[3:0]), 32'h0);

        // Channel 1 alone after reset.
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 16'h0);
        applyStimulus(1'b1, 2'b10, 2'b00, 2'b00, 16'h0);
        checkOutput("ch1_v0",    32'(rnd_f[7:4]), 32'h0);
        checkOutput("ch1_valid", 32'(valid_f),    32'h2);
        applyStimulus(1'b1, 2'b10, 2'b00, 2'b00, 16'h0);
        checkOutput("ch1_v1",    32'(rnd_f[7:4]), 32'h8);
        checkOutput("ch1_ch0",   32'(rnd_f[3:0]), 32'h0);

        // Reset in the middle of a burst, then the restart repeats the sequence.
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 16'h0);
        applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 16'h0);
        applyStimulus(1'b0, 2'b01, 2'b00, 2'b00, 16'h0);
        checkOutput("mid_rst_r", 32'(rnd_b),   32'h0);
        checkOutput("mid_rst_v", 32'(valid_b), 32'h0);
        applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 16'h0);
        checkOutput("rerun_v0",  32'(rnd_b[3:0]), 32'h0);
        applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 16'h0);
        checkOutput("rerun_v1",  32'(rnd_b[3:0]), 32'h8);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic          r;
            logic [CH-1:0] st_r, sp_r, ld_r;
            logic [15:0]   sd_r;
            r    = ($urandom_range(0, 50) != 0);
            st_r = CH'($urandom);
            sp_r = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
            ld_r = ($urandom_range(0, 12) == 0) ? CH'($urandom) : '0;
            sd_r = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            applyStimulus(r, st_r, sp_r, ld_r, sd_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
